// File: rtl/tl_phase_scheduler.sv
// Demand-driven A/B crossing phase scheduler with one walk phase and flash mode.
// Ports: clk, rstn, tick_en, a/b/ped_req, flash_en -> a/b_lamp, walk, ped_ack, phase, side.
module tl_phase_scheduler #(
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int PED_T     = 6
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick_en,
  input  logic       a_req,
  input  logic       b_req,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic [2:0] a_lamp,
  output logic [2:0] b_lamp,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase,
  output logic       side
);

  localparam logic [2:0] PH_GREEN  = 3'd0;
  localparam logic [2:0] PH_YELLOW = 3'd1;
  localparam logic [2:0] PH_ALLRED = 3'd2;
  localparam logic [2:0] PH_WALK   = 3'd3;
  localparam logic [2:0] PH_FLASH  = 3'd4;

  localparam int EW = CNT_W + 1;
  localparam logic [EW-1:0] G_MIN = EW'(GREEN_MIN);
  localparam logic [EW-1:0] G_MAX = EW'(GREEN_MAX);
  localparam logic [EW-1:0] Y_T   = EW'(YELLOW_T);
  localparam logic [EW-1:0] AR_T  = EW'(ALLRED_T);
  localparam logic [EW-1:0] P_T   = EW'(PED_T);

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  logic [2:0]       ph;
  logic [CNT_W-1:0] cnt;
  logic             ped_pend;
  logic             flash_ph;
  logic             ack_q;

  logic [EW-1:0]    el;
  logic [CNT_W-1:0] cnt_inc;
  logic             own;
  logic             oth;
  logic             dem;
  logic             ped_any;
  logic             go_yel;

  // elapsed is one wider than cnt so a saturated count never wraps
  assign el      = {1'b0, cnt} + EW'(1);
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  assign own     = side ? b_req : a_req;
  assign oth     = side ? a_req : b_req;
  assign ped_any = ped_pend | ped_req;
  assign dem     = oth | ped_any;
  assign go_yel  = (el >= G_MIN) && dem &&
                   (!own || (el >= G_MAX));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ph       <= PH_GREEN;
      side     <= 1'b0;
      cnt      <= '0;
      ped_pend <= 1'b0;
      flash_ph <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      ack_q    <= 1'b0;
      ped_pend <= ped_any;
      if (flash_en) begin
        if (ph != PH_FLASH) begin
          ph       <= PH_FLASH;
          cnt      <= '0;
          flash_ph <= 1'b1;
        end else if (tick_en) begin
          flash_ph <= ~flash_ph;
          cnt      <= cnt_inc;
        end
      end else begin
        case (ph)
          PH_GREEN: begin
            if (tick_en) begin
              if (go_yel) begin
                ph  <= PH_YELLOW;
                cnt <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          PH_YELLOW: begin
            if (tick_en) begin
              if (el == Y_T) begin
                ph  <= PH_ALLRED;
                cnt <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          PH_ALLRED: begin
            if (tick_en) begin
              if (el == AR_T) begin
                cnt <= '0;
                if (ped_any) begin
                  ph       <= PH_WALK;
                  ped_pend <= 1'b0;
                  ack_q    <= 1'b1;
                end else begin
                  ph   <= PH_GREEN;
                  side <= ~side;
                end
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          PH_WALK: begin
            if (tick_en) begin
              if (el == P_T) begin
                ph   <= PH_GREEN;
                side <= ~side;
                cnt  <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          PH_FLASH: begin
            // leave via clearance owned by B so A gets the next green
            ph       <= PH_ALLRED;
            side     <= 1'b1;
            cnt      <= '0;
            flash_ph <= 1'b0;
          end
          default: begin
            ph   <= PH_ALLRED;
            side <= 1'b1;
            cnt  <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    a_lamp = L_RED;
    b_lamp = L_RED;
    walk   = 1'b0;
    case (ph)
      PH_GREEN: begin
        a_lamp = side ? L_RED : L_GRN;
        b_lamp = side ? L_GRN : L_RED;
      end
      PH_YELLOW: begin
        a_lamp = side ? L_RED : L_YEL;
        b_lamp = side ? L_YEL : L_RED;
      end
      PH_WALK: begin
        walk = 1'b1;
      end
      PH_FLASH: begin
        a_lamp = {1'b0, flash_ph, 1'b0};
        b_lamp = {flash_ph, 2'b00};
      end
      default: begin
        a_lamp = L_RED;
        b_lamp = L_RED;
      end
    endcase
  end

  assign phase   = ph;
  assign ped_ack = ack_q;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Directed bench for tl_phase_scheduler.
// Hand-computed expectations for the default timing parameters.
module tb_tl_phase_scheduler;

  logic       clk;
  logic       rstn;
  logic       tick_en;
  logic       a_req;
  logic       b_req;
  logic       ped_req;
  logic       flash_en;
  logic [2:0] a_lamp;
  logic [2:0] b_lamp;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;
  logic       side;

  int checks = 0;
  int errors = 0;

  tl_phase_scheduler dut (
    .clk     (clk),
    .rstn    (rstn),
    .tick_en (tick_en),
    .a_req   (a_req),
    .b_req   (b_req),
    .ped_req (ped_req),
    .flash_en(flash_en),
    .a_lamp  (a_lamp),
    .b_lamp  (b_lamp),
    .walk    (walk),
    .ped_ack (ped_ack),
    .phase   (phase),
    .side    (side)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rstn     = 1'b0;
    tick_en  = 1'b0;
    a_req    = 1'b0;
    b_req    = 1'b0;
    ped_req  = 1'b0;
    flash_en = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  // one tick; returns at the negedge after the deciding posedge
  task automatic tick(input logic ped);
    @(negedge clk);
    tick_en = 1'b1;
    ped_req = ped;
    @(negedge clk);
    tick_en = 1'b0;
    ped_req = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (phase !== 3'd0 || side !== 1'b0) begin
      errors++;
      $display("FAIL reset_phase got %0d/%0d want 0/0", phase, side);
    end
    checks++;
    if (a_lamp !== 3'b001 || b_lamp !== 3'b100 ||
        walk !== 1'b0 || ped_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_lamps got %b %b %b %b want 001 100 0 0",
               a_lamp, b_lamp, walk, ped_ack);
    end
  endtask

  task automatic test_rest();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1'b0);
      if (phase !== 3'd0 || side !== 1'b0 ||
          a_lamp !== 3'b001 || b_lamp !== 3'b100) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rest_green got %0d bad ticks want 0", bad);
    end
  endtask

  task automatic test_demand();
    do_reset();
    b_req = 1'b1;
    ticks(3);
    checks++;
    if (phase !== 3'd0) begin
      errors++;
      $display("FAIL dem_min_green got %0d want 0", phase);
    end
    tick(1'b0);
    checks++;
    if (phase !== 3'd1 || a_lamp !== 3'b010 || b_lamp !== 3'b100) begin
      errors++;
      $display("FAIL dem_yellow got %0d %b %b want 1 010 100",
               phase, a_lamp, b_lamp);
    end
    tick(1'b0);
    checks++;
    if (phase !== 3'd1) begin
      errors++;
      $display("FAIL dem_yellow_len got %0d want 1", phase);
    end
    tick(1'b0);
    checks++;
    if (phase !== 3'd2 || a_lamp !== 3'b100 || b_lamp !== 3'b100) begin
      errors++;
      $display("FAIL dem_allred got %0d %b %b want 2 100 100",
               phase, a_lamp, b_lamp);
    end
    tick(1'b0);
    checks++;
    if (phase !== 3'd0 || side !== 1'b1 ||
        a_lamp !== 3'b100 || b_lamp !== 3'b001) begin
      errors++;
      $display("FAIL dem_b_green got %0d %0d %b %b want 0 1 100 001",
               phase, side, a_lamp, b_lamp);
    end
  endtask

  task automatic test_max_out();
    int n;
    do_reset();
    a_req = 1'b1;
    b_req = 1'b1;
    n = 0;
    while (phase == 3'd0 && n < 40) begin
      tick(1'b0);
      n++;
    end
    checks++;
    if (n != 12) begin
      errors++;
      $display("FAIL max_a_len got %0d want 12", n);
    end
    ticks(3);
    checks++;
    if (phase !== 3'd0 || side !== 1'b1) begin
      errors++;
      $display("FAIL max_b_start got %0d/%0d want 0/1", phase, side);
    end
    n = 0;
    while (phase == 3'd0 && n < 40) begin
      tick(1'b0);
      n++;
    end
    checks++;
    if (n != 12) begin
      errors++;
      $display("FAIL max_b_len got %0d want 12", n);
    end
  endtask

  task automatic goto_walk();
    do_reset();
    tick(1'b1);
    ticks(3);
    ticks(2);
    tick(1'b0);
  endtask

  task automatic test_ped();
    do_reset();
    tick(1'b1);
    ticks(2);
    checks++;
    if (phase !== 3'd0) begin
      errors++;
      $display("FAIL ped_hold_green got %0d want 0", phase);
    end
    tick(1'b0);
    checks++;
    if (phase !== 3'd1) begin
      errors++;
      $display("FAIL ped_yellow got %0d want 1", phase);
    end
    ticks(2);
    checks++;
    if (phase !== 3'd2) begin
      errors++;
      $display("FAIL ped_allred got %0d want 2", phase);
    end
    tick(1'b0);
    checks++;
    if (phase !== 3'd3 || walk !== 1'b1 || ped_ack !== 1'b1) begin
      errors++;
      $display("FAIL ped_walk_entry got %0d %b %b want 3 1 1",
               phase, walk, ped_ack);
    end
    @(negedge clk);
    checks++;
    if (ped_ack !== 1'b0 || walk !== 1'b1) begin
      errors++;
      $display("FAIL ped_ack_pulse got %b %b want 0 1", ped_ack, walk);
    end
    ticks(5);
    checks++;
    if (phase !== 3'd3) begin
      errors++;
      $display("FAIL ped_walk_len got %0d want 3", phase);
    end
    tick(1'b0);
    checks++;
    if (phase !== 3'd0 || side !== 1'b1 || walk !== 1'b0 ||
        b_lamp !== 3'b001) begin
      errors++;
      $display("FAIL ped_b_green got %0d %0d %b %b want 0 1 0 001",
               phase, side, walk, b_lamp);
    end
  endtask

  task automatic test_flash();
    do_reset();
    b_req = 1'b1;
    ticks(5);
    @(negedge clk);
    flash_en = 1'b1;
    @(negedge clk);
    checks++;
    if (phase !== 3'd4 || a_lamp !== 3'b010 || b_lamp !== 3'b100) begin
      errors++;
      $display("FAIL flash_entry got %0d %b %b want 4 010 100",
               phase, a_lamp, b_lamp);
    end
    tick(1'b0);
    checks++;
    if (a_lamp !== 3'b000 || b_lamp !== 3'b000 || walk !== 1'b0) begin
      errors++;
      $display("FAIL flash_off got %b %b %b want 000 000 0",
               a_lamp, b_lamp, walk);
    end
    tick(1'b0);
    checks++;
    if (a_lamp !== 3'b010) begin
      errors++;
      $display("FAIL flash_on got %b want 010", a_lamp);
    end
    flash_en = 1'b0;
    @(negedge clk);
    checks++;
    if (phase !== 3'd2 || side !== 1'b1) begin
      errors++;
      $display("FAIL flash_exit got %0d/%0d want 2/1", phase, side);
    end
    tick(1'b0);
    checks++;
    if (phase !== 3'd0 || side !== 1'b0 || a_lamp !== 3'b001) begin
      errors++;
      $display("FAIL flash_a_green got %0d %0d %b want 0 0 001",
               phase, side, a_lamp);
    end
  endtask

  task automatic test_reset_mid_walk();
    goto_walk();
    tick(1'b1);
    checks++;
    if (phase !== 3'd3) begin
      errors++;
      $display("FAIL rmw_in_walk got %0d want 3", phase);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (a_lamp !== 3'b001 || b_lamp !== 3'b100 || walk !== 1'b0) begin
      errors++;
      $display("FAIL rmw_async got %b %b %b want 001 100 0",
               a_lamp, b_lamp, walk);
    end
    @(negedge clk);
    rstn  = 1'b1;
    b_req = 1'b1;
    ticks(7);
    checks++;
    if (phase !== 3'd0 || side !== 1'b1 || walk !== 1'b0) begin
      errors++;
      $display("FAIL rmw_no_walk got %0d %0d %b want 0 1 0",
               phase, side, walk);
    end
  endtask

  initial begin
    test_reset();
    test_rest();
    test_demand();
    test_max_out();
    test_ped();
    test_flash();
    test_reset_mid_walk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
